// File: rtl/axi_burst_to_lite_pkg.sv
// Shared types, response codes and FSM encodings for the AXI4 -> AXI4-Lite burst splitter.
package axi_burst_to_lite_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] wr_state_e;
  localparam wr_state_e W_IDLE  = 3'd0;
  localparam wr_state_e W_DATA  = 3'd1;
  localparam wr_state_e W_ISSUE = 3'd2;
  localparam wr_state_e W_WAIT  = 3'd3;
  localparam wr_state_e W_RESP  = 3'd4;

  typedef logic [1:0] rd_state_e;
  localparam rd_state_e R_IDLE  = 2'd0;
  localparam rd_state_e R_ISSUE = 2'd1;
  localparam rd_state_e R_DATA  = 2'd2;

  // Numeric max gives DECERR > SLVERR > OKAY; EXOKAY is folded to OKAY.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = (a > b) ? a : b;
    if (r == RESP_EXOKAY) r = RESP_OKAY;
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; reserved encoding behaves as INCR.
module axi_burst_addr_gen
  import axi_burst_to_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [2:0]        size_i,
  input  burst_e            burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size_i;
    incr_addr = addr_i + step;
    wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
    unique case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_to_lite.sv
// AXI4 slave to AXI4-Lite master adapter: splits bursts into single-beat lite accesses,
// with independent read and write FSMs and an aggregated write response.
module axi_burst_to_lite
  import axi_burst_to_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic [7:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [STRB_W-1:0] s_wstrb,
  input  logic              s_wlast,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_wvalid,
  input  logic              m_wready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_bvalid,
  output logic              m_bready,
  input  logic [1:0]        m_bresp,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp
);

  localparam logic [2:0] MaxSize = 3'($clog2(STRB_W));

  wr_state_e         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_addr_next;
  logic [7:0]        wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic [2:0]        wr_size_q, wr_size_d;
  burst_e            wr_burst_q, wr_burst_d;
  logic [1:0]        wr_err_q, wr_err_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [STRB_W-1:0] wr_strb_q, wr_strb_d;
  logic              aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic              wr_last;

  rd_state_e         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_addr_next;
  logic [7:0]        rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [2:0]        rd_size_q, rd_size_d;
  burst_e            rd_burst_q, rd_burst_d;
  logic              rd_bad_q, rd_bad_d;
  logic              rd_last;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr_i      (wr_addr_q),
    .len_i       (wr_len_q),
    .size_i      (wr_size_q),
    .burst_i     (wr_burst_q),
    .next_addr_o (wr_addr_next)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr_i      (rd_addr_q),
    .len_i       (rd_len_q),
    .size_i      (rd_size_q),
    .burst_i     (rd_burst_q),
    .next_addr_o (rd_addr_next)
  );

  assign wr_last = (wr_cnt_q == wr_len_q);
  assign rd_last = (rd_cnt_q == rd_len_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_size_d  = wr_size_q;
    wr_burst_d = wr_burst_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    aw_pend_d  = aw_pend_q;
    w_pend_d   = w_pend_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          wr_id_d    = s_awid;
          wr_addr_d  = s_awaddr;
          wr_len_d   = s_awlen;
          wr_size_d  = s_awsize;
          wr_burst_d = burst_e'(s_awburst);
          wr_cnt_d   = 8'd0;
          wr_err_d   = (s_awburst == 2'b11 || s_awsize > MaxSize) ? RESP_SLVERR : RESP_OKAY;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          wr_data_d = s_wdata;
          wr_strb_d = s_wstrb;
          // Beat count follows len; a wlast disagreeing with it only poisons the response.
          if (s_wlast != wr_last) wr_err_d = worst_resp(wr_err_q, RESP_SLVERR);
          aw_pend_d  = 1'b1;
          w_pend_d   = 1'b1;
          wr_state_d = W_ISSUE;
        end
      end
      W_ISSUE: begin
        m_awvalid = aw_pend_q;
        m_wvalid  = w_pend_q;
        if (m_awready) aw_pend_d = 1'b0;
        if (m_wready)  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d) wr_state_d = W_WAIT;
      end
      W_WAIT: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          wr_err_d  = worst_resp(wr_err_q, m_bresp);
          wr_addr_d = wr_addr_next;
          if (wr_last) begin
            wr_state_d = W_RESP;
          end else begin
            wr_cnt_d   = wr_cnt_q + 8'd1;
            wr_state_d = W_DATA;
          end
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_size_d  = rd_size_q;
    rd_burst_d = rd_burst_q;
    rd_cnt_d   = rd_cnt_q;
    rd_bad_d   = rd_bad_q;
    s_arready  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_rvalid   = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          rd_id_d    = s_arid;
          rd_addr_d  = s_araddr;
          rd_len_d   = s_arlen;
          rd_size_d  = s_arsize;
          rd_burst_d = burst_e'(s_arburst);
          rd_cnt_d   = 8'd0;
          rd_bad_d   = (s_arburst == 2'b11) || (s_arsize > MaxSize);
          rd_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        m_rready = s_rready;
        s_rvalid = m_rvalid;
        if (m_rvalid && s_rready) begin
          rd_addr_d = rd_addr_next;
          if (rd_last) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d   = rd_cnt_q + 8'd1;
            rd_state_d = R_ISSUE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign s_bid    = wr_id_q;
  assign s_bresp  = wr_err_q;
  assign m_awaddr = wr_addr_q;
  assign m_wdata  = wr_data_q;
  assign m_wstrb  = wr_strb_q;
  assign m_araddr = rd_addr_q;
  assign s_rid    = rd_id_q;
  assign s_rdata  = m_rdata;
  assign s_rlast  = rd_last;
  assign s_rresp  = worst_resp(m_rresp, rd_bad_q ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= BURST_FIXED;
      wr_cnt_q   <= '0;
      wr_err_q   <= RESP_OKAY;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      aw_pend_q  <= 1'b0;
      w_pend_q   <= 1'b0;
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= BURST_FIXED;
      rd_cnt_q   <= '0;
      rd_bad_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_size_q  <= wr_size_d;
      wr_burst_q <= wr_burst_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      aw_pend_q  <= aw_pend_d;
      w_pend_q   <= w_pend_d;
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_size_q  <= rd_size_d;
      rd_burst_q <= rd_burst_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_bad_q   <= rd_bad_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_to_lite.sv
// Directed bench for axi_burst_to_lite: AXI4 master tasks on the slave side, a lite slave model
// with optional random stalls on the master side, and hand-computed expected values.
module tb_axi_burst_to_lite;
  import axi_burst_to_lite_pkg::*;

  localparam int Tmo = 400;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [3:0]  s_awid, s_bid, s_arid, s_rid;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_wstrb, m_wstrb;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [1:0]  m_bresp, m_rresp;

  always #5 aclk = ~aclk;

  axi_burst_to_lite #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  bit          stall_en = 1'b0;
  bit          hold_b = 1'b0;
  logic [31:0] wlog_addr[$], wlog_data[$], rlog_addr[$];
  logic [3:0]  wlog_strb[$];
  logic [1:0]  bresp_plan[$];
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic [3:0]  r_id[$];
  logic [31:0] r_data[$];
  logic [1:0]  r_resp[$];
  logic        r_last[$];
  logic [31:0] wbeat[16];
  bit          wlast_flip[16];
  logic [31:0] exp_addr[16];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic rdy();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // Lite slave: sample handshakes at negedge, update outputs just after posedge.
  initial begin : lite_slave
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_got, w_got, aw_st, w_st, ar_st, b_st;
    logic [31:0] aw_a, w_d, ar_a, aw_l, w_l, aw_p, w_p, ar_p;
    logic [3:0] w_s, s_l;
    logic [5:0] b_p;
    aw_got = 0; w_got = 0; aw_st = 0; w_st = 0; ar_st = 0; b_st = 0;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_bresp = 0;
    m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge aclk);
      if (aw_st) check_eq("aw_hold", {m_awvalid, m_awaddr}, {1'b1, aw_p});
      if (w_st)  check_eq("w_hold", {m_wvalid, m_wdata}, {1'b1, w_p});
      if (ar_st) check_eq("ar_hold", {m_arvalid, m_araddr}, {1'b1, ar_p});
      if (b_st)  check_eq("b_hold", {s_bvalid, s_bid, s_bresp}, {1'b1, b_p});
      aw_st = aresetn && m_awvalid && !m_awready; aw_p = m_awaddr;
      w_st  = aresetn && m_wvalid && !m_wready;   w_p  = m_wdata;
      ar_st = aresetn && m_arvalid && !m_arready; ar_p = m_araddr;
      b_st  = aresetn && s_bvalid && !s_bready;   b_p  = {s_bid, s_bresp};
      aw_hs = m_awvalid && m_awready; aw_a = m_awaddr;
      w_hs  = m_wvalid && m_wready;   w_d  = m_wdata; w_s = m_wstrb;
      b_hs  = m_bvalid && m_bready;
      ar_hs = m_arvalid && m_arready; ar_a = m_araddr;
      r_hs  = m_rvalid && m_rready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        aw_got = 0; w_got = 0; aw_st = 0; w_st = 0; ar_st = 0; b_st = 0;
        m_bvalid = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_arready = 0;
      end else begin
        if (aw_hs) begin aw_got = 1; aw_l = aw_a; end
        if (w_hs) begin w_got = 1; w_l = w_d; s_l = w_s; end
        if (b_hs) m_bvalid = 0;
        if (aw_got && w_got && !m_bvalid && !hold_b) begin
          wlog_addr.push_back(aw_l);
          wlog_data.push_back(w_l);
          wlog_strb.push_back(s_l);
          m_bresp  = (bresp_plan.size() > 0) ? bresp_plan.pop_front() : RESP_OKAY;
          m_bvalid = 1;
          aw_got = 0; w_got = 0;
        end
        if (r_hs) m_rvalid = 0;
        if (ar_hs) begin
          rlog_addr.push_back(ar_a);
          m_rvalid = 1; m_rdata = rd_fn(ar_a); m_rresp = RESP_OKAY;
        end
        m_awready = rdy(); m_wready = rdy(); m_arready = rdy();
      end
    end
  end

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); wlog_strb.delete(); rlog_addr.delete();
    bresp_plan.delete(); r_id.delete(); r_data.delete(); r_resp.delete(); r_last.delete();
    for (int i = 0; i < 16; i++) wlast_flip[i] = 0;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int n;
    logic hs;
    s_awvalid = 1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size;
    s_awburst = burst;
    n = 0; hs = 0;
    while (!hs && n < Tmo) begin
      @(negedge aclk); hs = s_awready; @(posedge aclk); #1; n++;
    end
    s_awvalid = 0;
    if (!hs) begin check_eq("aw_timeout", hs, 1'b1); return; end
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1; s_wdata = wbeat[i]; s_wstrb = 4'hF;
      s_wlast = (i == int'(len)) ^ wlast_flip[i];
      n = 0; hs = 0;
      while (!hs && n < Tmo) begin
        @(negedge aclk); hs = s_wready; @(posedge aclk); #1; n++;
      end
      s_wvalid = 0; s_wlast = 0;
      if (!hs) begin check_eq("w_timeout", hs, 1'b1); return; end
    end
    n = 0; hs = 0;
    while (!hs && n < Tmo) begin
      s_bready = rdy();
      @(negedge aclk);
      if (s_bvalid && s_bready) begin hs = 1; b_id = s_bid; b_resp = s_bresp; end
      @(posedge aclk); #1; n++;
    end
    s_bready = 0;
    if (!hs) check_eq("b_timeout", hs, 1'b1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    logic hs;
    s_arvalid = 1; s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size;
    s_arburst = burst;
    n = 0; hs = 0;
    while (!hs && n < Tmo) begin
      @(negedge aclk); hs = s_arready; @(posedge aclk); #1; n++;
    end
    s_arvalid = 0;
    if (!hs) begin check_eq("ar_timeout", hs, 1'b1); return; end
    n = 0;
    while (r_data.size() < int'(len) + 1 && n < Tmo) begin
      s_rready = rdy();
      @(negedge aclk);
      if (s_rvalid && s_rready) begin
        r_id.push_back(s_rid); r_data.push_back(s_rdata);
        r_resp.push_back(s_rresp); r_last.push_back(s_rlast);
      end
      @(posedge aclk); #1; n++;
    end
    s_rready = 0;
    if (n >= Tmo) check_eq("r_timeout", r_data.size(), int'(len) + 1);
  endtask

  task automatic check_rd(input string tag, input int nb, input logic [3:0] id,
                          input logic [1:0] resp);
    check_eq({tag, "_nar"}, rlog_addr.size(), nb);
    check_eq({tag, "_nr"}, r_data.size(), nb);
    for (int i = 0; i < nb && i < r_data.size() && i < rlog_addr.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), rlog_addr[i], exp_addr[i]);
      check_eq($sformatf("%s_data%0d", tag, i), r_data[i], rd_fn(exp_addr[i]));
      check_eq($sformatf("%s_id%0d", tag, i), r_id[i], id);
      check_eq($sformatf("%s_last%0d", tag, i), r_last[i], i == nb - 1);
      check_eq($sformatf("%s_resp%0d", tag, i), r_resp[i], resp);
    end
  endtask

  task automatic check_wr(input string tag, input int nb);
    check_eq({tag, "_nbeats"}, wlog_addr.size(), nb);
    for (int i = 0; i < nb && i < wlog_addr.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), wlog_addr[i], exp_addr[i]);
      check_eq($sformatf("%s_data%0d", tag, i), wlog_data[i], wbeat[i]);
      check_eq($sformatf("%s_strb%0d", tag, i), wlog_strb[i], 4'hF);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0;
    clear_logs();
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_ready", {s_awready, s_arready, s_wready}, 3'b110);
    check_eq("rst_valid", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready},
             7'b0);
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;

    // Single write
    clear_logs(); wbeat[0] = 32'hDEADBEEF; exp_addr[0] = 32'h10;
    axi_write(4'd3, 32'h10, 8'd0, 3'd2, BURST_INCR);
    check_wr("single", 1);
    check_eq("single_bid", b_id, 4'd3);
    check_eq("single_bresp", b_resp, RESP_OKAY);

    // INCR read
    clear_logs();
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h104; exp_addr[2] = 32'h108; exp_addr[3] = 32'h10C;
    axi_read(4'd5, 32'h100, 8'd3, 3'd2, BURST_INCR);
    check_rd("incr_rd", 4, 4'd5, RESP_OKAY);

    // WRAP read
    clear_logs();
    exp_addr[0] = 32'h38; exp_addr[1] = 32'h3C; exp_addr[2] = 32'h30; exp_addr[3] = 32'h34;
    axi_read(4'd1, 32'h38, 8'd3, 3'd2, BURST_WRAP);
    check_rd("wrap_rd", 4, 4'd1, RESP_OKAY);

    // Reserved burst read behaves as INCR with SLVERR on every beat
    clear_logs(); exp_addr[0] = 32'h80; exp_addr[1] = 32'h84;
    axi_read(4'd2, 32'h80, 8'd1, 3'd2, 2'b11);
    check_rd("rsvd_rd", 2, 4'd2, RESP_SLVERR);

    // Error aggregation: SLVERR on second beat
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      wbeat[i] = 32'h1111_0000 + 32'(i); exp_addr[i] = 32'h200 + 32'(4 * i);
    end
    bresp_plan.push_back(RESP_OKAY); bresp_plan.push_back(RESP_SLVERR);
    bresp_plan.push_back(RESP_OKAY); bresp_plan.push_back(RESP_OKAY);
    axi_write(4'd8, 32'h200, 8'd3, 3'd2, BURST_INCR);
    check_wr("agg", 4);
    check_eq("agg_bid", b_id, 4'd8);
    check_eq("agg_bresp", b_resp, RESP_SLVERR);

    // Premature wlast on first beat of a 3-beat write
    clear_logs(); wlast_flip[0] = 1;
    for (int i = 0; i < 3; i++) exp_addr[i] = 32'h240 + 32'(4 * i);
    axi_write(4'd4, 32'h240, 8'd2, 3'd2, BURST_INCR);
    check_wr("wlast", 3);
    check_eq("wlast_bresp", b_resp, RESP_SLVERR);

    // FIXED write, DECERR outranks SLVERR
    clear_logs(); exp_addr[0] = 32'h40; exp_addr[1] = 32'h40;
    bresp_plan.push_back(RESP_DECERR); bresp_plan.push_back(RESP_SLVERR);
    axi_write(4'd7, 32'h40, 8'd1, 3'd2, BURST_FIXED);
    check_wr("fixed", 2);
    check_eq("fixed_bresp", b_resp, RESP_DECERR);

    // Oversized beat size is flagged but still issued
    clear_logs(); exp_addr[0] = 32'h700;
    axi_write(4'd2, 32'h700, 8'd0, 3'd3, BURST_INCR);
    check_wr("size", 1);
    check_eq("size_bresp", b_resp, RESP_SLVERR);

    // Concurrent bursts under random backpressure
    clear_logs(); stall_en = 1;
    for (int i = 0; i < 8; i++) wbeat[i] = 32'hA000_0000 + 32'(i * 17);
    fork
      axi_write(4'd9, 32'h300, 8'd7, 3'd2, BURST_INCR);
      axi_read(4'hA, 32'h400, 8'd7, 3'd2, BURST_INCR);
    join
    stall_en = 0;
    for (int i = 0; i < 8; i++) exp_addr[i] = 32'h300 + 32'(4 * i);
    check_wr("bp_wr", 8);
    check_eq("bp_bid", b_id, 4'd9);
    check_eq("bp_bresp", b_resp, RESP_OKAY);
    for (int i = 0; i < 8; i++) exp_addr[i] = 32'h400 + 32'(4 * i);
    check_rd("bp_rd", 8, 4'hA, RESP_OKAY);

    // Asynchronous reset while waiting for the lite write response
    clear_logs(); hold_b = 1;
    s_awvalid = 1; s_awid = 4'd4; s_awaddr = 32'h500; s_awlen = 0; s_awsize = 2;
    s_awburst = BURST_INCR;
    @(posedge aclk); #1;
    s_awvalid = 0; s_wvalid = 1; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF; s_wlast = 1;
    @(posedge aclk); #1;
    s_wvalid = 0; s_wlast = 0;
    n = 0;
    while (!m_bready && n < 20) begin @(posedge aclk); #1; n++; end
    check_eq("rst_wait_reached", m_bready, 1'b1);
    #2 aresetn = 0;
    #1;
    check_eq("rst_mid", {s_bvalid, m_awvalid, m_wvalid, m_arvalid, m_bready, s_awready}, 6'b000001);
    @(posedge aclk); #1;
    hold_b = 0;
    @(negedge aclk) aresetn = 1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    clear_logs(); wbeat[0] = 32'hCAFEF00D; exp_addr[0] = 32'h600;
    axi_write(4'd6, 32'h600, 8'd0, 3'd2, BURST_INCR);
    check_wr("post_rst", 1);
    check_eq("post_rst_bid", b_id, 4'd6);
    check_eq("post_rst_bresp", b_resp, RESP_OKAY);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
